// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one Avalon-MM SDRAM controller slave port between two masters.
// Per-command round-robin grant, command lock while the slave stalls, and an
// in-order tag FIFO that steers read data back to the issuing master.
// Optional build macro: SDRAM_ARB_FIXED_PRIO_EN (master 0 always wins ties).
//
// Handshake: a command is "presented" when s_read or s_write is high; it is
// accepted on a rising clock edge where s_waitrequest is low. A master's
// command is taken on the edge where its mN_waitrequest is low while it holds
// mN_read/mN_write. Read data is returned one beat per s_readdatavalid, in
// command order, with no flow control on the return path.

module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,

    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [DATA_W/8-1:0]         m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,

    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [DATA_W/8-1:0]         m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,

    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [DATA_W/8-1:0]         s_byteenable,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,

    output logic [$clog2(MAX_PEND):0]   pend_count,
    output logic                        err_underflow
);

    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;

    // Arbitration and command path
    logic req0;
    logic req1;
    logic cand0;
    logic cand1;
    logic gnt_valid;
    logic gnt_id;
    logic sel_read;
    logic sel_write;
    logic presented;
    logic accept;

    // Lock keeps a stalled command on the slave port until it is taken
    logic lock_q;
    logic lock_d;
    logic lock_id_q;
    logic lock_id_d;

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    // Id of the master whose command was accepted most recently
    logic last_id_q;
    logic last_id_d;
`endif

    // Tag FIFO: one bit per outstanding read, holding the issuing master id
    logic [MAX_PEND-1:0] tag_q;
    logic [MAX_PEND-1:0] tag_d;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                head_id;

    logic err_q;
    logic err_d;

    // FIFO occupancy flags derived from the registered count
    always_comb begin
        fifo_full  = (cnt_q == CNT_W'(MAX_PEND));
        fifo_empty = (cnt_q == '0);
        head_id    = tag_q[rd_ptr_q];
    end

    // Grant selection: lock wins, then round-robin (or fixed) among candidates.
    // A reader is not a candidate while the tag FIFO is full, which lets the
    // other master's write through.
    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        cand0     = req0 & ~(m0_read & fifo_full);
        cand1     = req1 & ~(m1_read & fifo_full);
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else if (cand0 && cand1) begin
            gnt_valid = 1'b1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            gnt_id    = 1'b0;
`else
            gnt_id    = ~last_id_q;
`endif
        end else if (cand0) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (cand1) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    // Command mux toward the controller and waitrequest back to the masters.
    // A read is never presented while the FIFO is full, even if a pop is
    // happening in the same cycle.
    always_comb begin
        sel_read       = gnt_id ? m1_read      : m0_read;
        sel_write      = gnt_id ? m1_write     : m0_write;
        s_address      = gnt_id ? m1_address   : m0_address;
        s_writedata    = gnt_id ? m1_writedata : m0_writedata;
        s_byteenable   = gnt_id ? m1_byteenable : m0_byteenable;
        s_read         = gnt_valid & sel_read & ~fifo_full;
        s_write        = gnt_valid & sel_write;
        presented      = s_read | s_write;
        accept         = presented & ~s_waitrequest;
        m0_waitrequest = ~(presented & ~gnt_id) | s_waitrequest;
        m1_waitrequest = ~(presented &  gnt_id) | s_waitrequest;
    end

    // Lock and round-robin history next state
    always_comb begin
        lock_d    = presented & s_waitrequest;
        lock_id_d = presented ? gnt_id : lock_id_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        last_id_d = accept ? gnt_id : last_id_q;
`endif
    end

    // Tag FIFO push/pop, occupancy count and sticky underflow flag
    always_comb begin
        push     = accept & s_read;
        pop      = s_readdatavalid & ~fifo_empty;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            tag_d[wr_ptr_q] = gnt_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (s_readdatavalid & fifo_empty);
    end

    // Read return steering: combinational from the controller's valid strobe
    always_comb begin
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = s_readdatavalid & ~fifo_empty & ~head_id;
        m1_readdatavalid = s_readdatavalid & ~fifo_empty &  head_id;
        pend_count       = cnt_q;
        err_underflow    = err_q;
    end

    // State registers; everything clears immediately on reset
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_id_q <= 1'b1;
`endif
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_id_q <= last_id_d;
`endif
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed cycle-by-cycle stimulus, with
// expected accepted commands and read returns queued by the stimulus and
// compared by a monitor on the falling clock edge.

module tb_sdram_port_arbiter;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 16;
    localparam int MAX_PEND = 8;
    localparam int CMD_W    = 2 + 2 + ADDR_W + DATA_W + DATA_W/8;
    localparam int RD_W     = 2 + 2*DATA_W;

    logic                  clk_clk = 1'b0;
    logic                  reset_reset_n = 1'b0;
    logic [ADDR_W-1:0]     m0_address, m1_address;
    logic                  m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0]     m0_writedata, m1_writedata;
    logic [DATA_W/8-1:0]   m0_byteenable, m1_byteenable;
    logic                  m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]     m0_readdata, m1_readdata;
    logic                  m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]     s_address;
    logic                  s_read, s_write;
    logic [DATA_W-1:0]     s_writedata;
    logic [DATA_W/8-1:0]   s_byteenable;
    logic                  s_waitrequest;
    logic [DATA_W-1:0]     s_readdata;
    logic                  s_readdatavalid;
    logic [$clog2(MAX_PEND):0] pend_count;
    logic                  err_underflow;

    int total = 0;
    int bad   = 0;
    logic [CMD_W-1:0] exp_cmd_q[$];
    logic [RD_W-1:0]  exp_rd_q[$];
    logic [CMD_W-1:0] cur_cmd;
    logic [RD_W-1:0]  cur_rd;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .pend_count(pend_count), .err_underflow(err_underflow)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_clk = ~clk_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    endtask

    task automatic drive_m(input logic id, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input logic [DATA_W/8-1:0] be);
        if (id) begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = wd; m1_byteenable = be;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = wd; m0_byteenable = be;
        end
    endtask

    // Expected accepted command: {m1_waitrequest, m0_waitrequest, s_read, s_write, addr, wdata, be}
    task automatic exp_cmd(input logic id, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input logic [DATA_W/8-1:0] be);
        logic [1:0] w;
        w = id ? 2'b01 : 2'b10;
        exp_cmd_q.push_back({w, rd, wr, a, wd, be});
    endtask

    // Expected read return: {m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata}
    task automatic exp_rd(input logic id, input logic [DATA_W-1:0] d);
        exp_rd_q.push_back({id, ~id, d, d});
    endtask

    task automatic ret(input logic [DATA_W-1:0] d);
        s_readdatavalid = 1'b1;
        s_readdata      = d;
    endtask

    task automatic ret_off();
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                cur_cmd = {m1_waitrequest, m0_waitrequest, s_read, s_write,
                           s_address, s_writedata, s_byteenable};
                if (exp_cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cmd_unexpected: got %0h expected none", cur_cmd);
                end else begin
                    check("cmd", 64'(cur_cmd), 64'(exp_cmd_q.pop_front()));
                end
            end
            if (m0_readdatavalid || m1_readdatavalid) begin
                cur_rd = {m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata};
                if (exp_rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %0h expected none", cur_rd);
                end else begin
                    check("rd_return", 64'(cur_rd), 64'(exp_rd_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic              gid;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;

        idle();
        s_waitrequest = 1'b0;
        ret_off();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        check("rst_pend",   64'(pend_count),       64'd0);
        check("rst_err",    64'(err_underflow),    64'd0);
        check("rst_s_read", 64'(s_read),           64'd0);
        check("rst_s_write",64'(s_write),          64'd0);
        check("rst_m0_rdv", 64'(m0_readdatavalid), 64'd0);
        check("rst_m1_rdv", 64'(m1_readdatavalid), 64'd0);
        reset_reset_n = 1'b1;
        next();

        // Single master read, controller latency 3
        drive_m(1'b0, 1'b1, 1'b0, 25'h10, 16'h0, 2'b00);
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h10, 16'h0, 2'b00);
        settle();
        check("t1_s_read_same_cycle", 64'(s_read), 64'd1);
        next();
        idle();
        check("t1_pend_one", 64'(pend_count), 64'd1);
        next();
        next();
        ret(16'h1234);
        exp_rd(1'b0, 16'h1234);
        settle();
        check("t1_m1_rdv_low", 64'(m1_readdatavalid), 64'd0);
        next();
        ret_off();
        check("t1_pend_zero", 64'(pend_count), 64'd0);

        // Contention from a fresh reset: alternating grants (all m0 if fixed)
        reset_reset_n = 1'b0;
        settle();
        check("t2_rst_pend", 64'(pend_count), 64'd0);
        next();
        reset_reset_n = 1'b1;
        next();
        drive_m(1'b0, 1'b1, 1'b0, 25'h100, 16'h0, 2'b00);
        drive_m(1'b1, 1'b1, 1'b0, 25'h200, 16'h0, 2'b00);
        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            gid = 1'b0;
`else
            gid = i[0];
`endif
            exp_cmd(gid, 1'b1, 1'b0, gid ? 25'h200 : 25'h100, 16'h0, 2'b00);
            next();
        end
        idle();
        check("t2_pend_four", 64'(pend_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            gid = 1'b0;
`else
            gid = i[0];
`endif
            d = 16'hC000 + 16'(i);
            ret(d);
            exp_rd(gid, d);
            next();
        end
        ret_off();
        check("t2_pend_zero", 64'(pend_count), 64'd0);

        // Lock: m1 write stalled 4 cycles while m0 also requests
        s_waitrequest = 1'b1;
        drive_m(1'b1, 1'b0, 1'b1, 25'h3, 16'hBEEF, 2'b11);
        settle();
        check("t3_s_write", 64'(s_write), 64'd1);
        check("t3_m1_wait", 64'(m1_waitrequest), 64'd1);
        for (int i = 1; i < 4; i++) begin
            next();
            drive_m(1'b0, 1'b1, 1'b0, 25'h40, 16'h0, 2'b00);
            settle();
            check("t3_lock_addr", 64'(s_address), 64'h3);
            check("t3_lock_m0_wait", 64'(m0_waitrequest), 64'd1);
            check("t3_lock_no_read", 64'(s_read), 64'd0);
        end
        next();
        s_waitrequest = 1'b0;
        exp_cmd(1'b1, 1'b0, 1'b1, 25'h3, 16'hBEEF, 2'b11);
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h40, 16'h0, 2'b00);
        settle();
        check("t3_accept_addr", 64'(s_address), 64'h3);
        next();
        drive_m(1'b1, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        settle();
        check("t3_m0_after_lock", 64'(s_address), 64'h40);
        next();
        idle();
        check("t3_pend_one", 64'(pend_count), 64'd1);
        ret(16'h5555);
        exp_rd(1'b0, 16'h5555);
        next();
        ret_off();
        check("t3_pend_zero", 64'(pend_count), 64'd0);

        // Full FIFO: 8 reads outstanding blocks the 9th; writes still pass
        for (int i = 0; i < 8; i++) begin
            a = 25'h80 + ADDR_W'(i);
            drive_m(1'b0, 1'b1, 1'b0, a, 16'h0, 2'b00);
            exp_cmd(1'b0, 1'b1, 1'b0, a, 16'h0, 2'b00);
            next();
        end
        drive_m(1'b0, 1'b1, 1'b0, 25'h88, 16'h0, 2'b00);
        settle();
        check("t4_pend_full",   64'(pend_count),     64'd8);
        check("t4_m0_blocked",  64'(m0_waitrequest), 64'd1);
        check("t4_s_read_low",  64'(s_read),         64'd0);
        check("t4_s_write_low", 64'(s_write),        64'd0);
        next();
        drive_m(1'b1, 1'b0, 1'b1, 25'h9, 16'h1111, 2'b01);
        exp_cmd(1'b1, 1'b0, 1'b1, 25'h9, 16'h1111, 2'b01);
        settle();
        check("t4_m1_write_passes", 64'(s_write), 64'd1);
        check("t4_m0_still_blocked", 64'(m0_waitrequest), 64'd1);
        next();
        drive_m(1'b1, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        ret(16'h0F00);
        exp_rd(1'b0, 16'h0F00);
        settle();
        check("t4_pop_cycle_blocked", 64'(m0_waitrequest), 64'd1);
        check("t4_pop_cycle_no_read", 64'(s_read), 64'd0);
        next();
        ret_off();
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h88, 16'h0, 2'b00);
        settle();
        check("t4_read_after_pop", 64'(s_read), 64'd1);
        check("t4_pend_seven", 64'(pend_count), 64'd7);
        next();
        idle();
        check("t4_pend_refull", 64'(pend_count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            d = 16'h0F00 + 16'(i);
            ret(d);
            exp_rd(1'b0, d);
            next();
        end
        ret_off();
        check("t4_pend_zero", 64'(pend_count), 64'd0);

        // Interleaved return order m0,m1,m1,m0 plus a push/pop cycle
        drive_m(1'b0, 1'b1, 1'b0, 25'h500, 16'h0, 2'b00);
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h500, 16'h0, 2'b00);
        next();
        idle();
        drive_m(1'b1, 1'b1, 1'b0, 25'h600, 16'h0, 2'b00);
        exp_cmd(1'b1, 1'b1, 1'b0, 25'h600, 16'h0, 2'b00);
        next();
        drive_m(1'b1, 1'b1, 1'b0, 25'h601, 16'h0, 2'b00);
        exp_cmd(1'b1, 1'b1, 1'b0, 25'h601, 16'h0, 2'b00);
        next();
        idle();
        drive_m(1'b0, 1'b1, 1'b0, 25'h501, 16'h0, 2'b00);
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h501, 16'h0, 2'b00);
        next();
        check("t5_pend_four", 64'(pend_count), 64'd4);
        drive_m(1'b0, 1'b1, 1'b0, 25'h502, 16'h0, 2'b00);
        exp_cmd(1'b0, 1'b1, 1'b0, 25'h502, 16'h0, 2'b00);
        ret(16'h00D0);
        exp_rd(1'b0, 16'h00D0);
        next();
        idle();
        check("t5_push_pop_pend", 64'(pend_count), 64'd4);
        ret(16'h00D1); exp_rd(1'b1, 16'h00D1); next();
        ret(16'h00D2); exp_rd(1'b1, 16'h00D2); next();
        ret(16'h00D3); exp_rd(1'b0, 16'h00D3); next();
        ret(16'h00D4); exp_rd(1'b0, 16'h00D4); next();
        ret_off();
        check("t5_pend_zero", 64'(pend_count), 64'd0);

        // Underflow: stray readdatavalid with nothing outstanding
        check("t6_err_before", 64'(err_underflow), 64'd0);
        ret(16'hDEAD);
        settle();
        check("t6_m0_rdv_low", 64'(m0_readdatavalid), 64'd0);
        check("t6_m1_rdv_low", 64'(m1_readdatavalid), 64'd0);
        next();
        ret_off();
        check("t6_err_set", 64'(err_underflow), 64'd1);
        check("t6_pend_zero", 64'(pend_count), 64'd0);
        next();
        next();
        check("t6_err_sticky", 64'(err_underflow), 64'd1);
        reset_reset_n = 1'b0;
        settle();
        check("t6_err_reset", 64'(err_underflow), 64'd0);
        next();
        reset_reset_n = 1'b1;
        next();

        // ---------------- final report ----------------
        check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
        check("rd_queue_drained",  64'(exp_rd_q.size()),  64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
